// File: rtl/spi_slave_pkg.sv
// spi_slave_pkg: frame geometry, status word layout and FSM states shared by the SPI slave port
package spi_slave_pkg;
  localparam int FRAME_BITS = 32;
  localparam int INDEX_W = 4;
  localparam int DATA_W = 28;
  localparam int CNT_W = 6;
  localparam int STAT_FLAGS_HI = 27;
  localparam int STAT_FLAGS_LO = 24;
  localparam int STAT_COUNT_HI = 23;
  localparam int STAT_COUNT_LO = 11;
  localparam int STAT_ERR_HI = 10;
  localparam int STAT_ERR_LO = 3;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SHIFT = 2'd1, ST_CHECK = 2'd2} state_t;
  // Status word returned when the transmit FIFO is empty; unused bits stay 0
  function automatic logic [FRAME_BITS-1:0] status_word(input logic [3:0] flags, input logic [12:0] count, input logic [7:0] errs);
    logic [FRAME_BITS-1:0] w;
    w = '0;
    w[STAT_FLAGS_HI:STAT_FLAGS_LO] = flags;
    w[STAT_COUNT_HI:STAT_COUNT_LO] = count;
    w[STAT_ERR_HI:STAT_ERR_LO] = errs;
    return w;
  endfunction
endpackage

// File: rtl/spi_slave_port_sync_edge.sv
// sync_edge: multi-flop synchronizer with rise/fall detection on the synchronized level
module sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic q,
  output logic rise,
  output logic fall
);
  logic [STAGES-1:0] sr;
  logic prev;
  // shift the asynchronous input through the chain and remember the previous synchronized sample
  always_ff @(posedge clk)
    if (!rst_n) begin
      sr <= '0;
      prev <= 1'b0;
    end else begin
      sr <= (sr << 1) | STAGES'(din);
      prev <= q;
    end
  assign q = sr[STAGES-1];
  assign rise = q & ~prev;
  assign fall = ~q & prev;
endmodule

// File: rtl/spi_slave_port.sv
// spi_slave_port: SPI mode 0 slave exchanging 32-bit frames; SPI_FRAME_ERR_CNT_EN adds the err_cnt output
module spi_slave_port
  import spi_slave_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  spi_clk,
  input  logic                  spi_mosi,
  input  logic                  spi_cs,
  output logic                  spi_miso,
  output logic                  rx_valid,
  output logic [INDEX_W-1:0]    rx_index,
  output logic [DATA_W-1:0]     rx_data,
  input  logic                  tx_valid,
  input  logic [FRAME_BITS-1:0] tx_data,
  output logic                  tx_ready,
  input  logic [3:0]            stat_flags,
  input  logic [12:0]           stat_count,
  output logic                  frame_err
`ifdef SPI_FRAME_ERR_CNT_EN
  ,
  output logic [7:0]            err_cnt
`endif
);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FRAME_BITS + 1);
  state_t state;
  logic [CNT_W-1:0] cnt;
  logic [FRAME_BITS-1:0] rx_sr, tx_sr;
  logic from_fifo, pend, done, full;
  logic sclk_rise, sclk_fall, cs_rise, cs_fall, mosi;
  logic sclk_lvl_unused, cs_lvl_unused, mosi_rise_unused, mosi_fall_unused;
  logic [7:0] errs;
  sync_edge #(.STAGES(SYNC_STAGES)) u_sclk (
    .clk(clk), .rst_n(rst_n), .din(spi_clk), .q(sclk_lvl_unused), .rise(sclk_rise), .fall(sclk_fall)
  );
  sync_edge #(.STAGES(SYNC_STAGES)) u_mosi (
    .clk(clk), .rst_n(rst_n), .din(spi_mosi), .q(mosi), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
  );
  sync_edge #(.STAGES(SYNC_STAGES)) u_cs (
    .clk(clk), .rst_n(rst_n), .din(spi_cs), .q(cs_lvl_unused), .rise(cs_rise), .fall(cs_fall)
  );
  assign done = (state == ST_SHIFT) && cs_rise;
  assign full = (cnt == CNT_FULL);
  assign spi_miso = (state == ST_SHIFT) && tx_sr[FRAME_BITS-1];
`ifdef SPI_FRAME_ERR_CNT_EN
  assign err_cnt = errs;
  // saturating count of malformed frames
  always_ff @(posedge clk)
    if (!rst_n) errs <= '0;
    else if (frame_err && errs != 8'hff) errs <= errs + 8'd1;
`else
  assign errs = '0;
`endif
  // frame FSM; a cs fall seen during CHECK is held in pend so the load happens after the FIFO pop settles
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt <= '0;
      rx_sr <= '0;
      tx_sr <= '0;
      from_fifo <= 1'b0;
      pend <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (cs_fall || pend) begin
          state <= ST_SHIFT;
          cnt <= '0;
          pend <= 1'b0;
          tx_sr <= tx_valid ? tx_data : status_word(stat_flags, stat_count, errs);
          from_fifo <= tx_valid;
        end
        ST_SHIFT: begin
          if (sclk_rise) begin
            rx_sr <= {rx_sr[FRAME_BITS-2:0], mosi};
            cnt <= (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
          end
          if (sclk_fall) tx_sr <= tx_sr << 1;
          if (cs_rise) state <= ST_CHECK;
        end
        default: begin
          state <= ST_IDLE;
          pend <= cs_fall;
        end
      endcase
    end
  // frame outcome strobes, asserted for the single CHECK cycle; payload holds until the next good frame
  always_ff @(posedge clk)
    if (!rst_n) begin
      rx_valid <= 1'b0;
      tx_ready <= 1'b0;
      frame_err <= 1'b0;
      rx_index <= '0;
      rx_data <= '0;
    end else begin
      rx_valid <= done && full;
      tx_ready <= done && full && from_fifo;
      frame_err <= done && !full;
      if (done && full) {rx_index, rx_data} <= rx_sr;
    end
endmodule

// File: tb/tb_spi_slave_port.sv
// tb_spi_slave_port: directed self-checking bench for spi_slave_port
module tb_spi_slave_port;
  logic clk = 1'b0, rst_n = 1'b0;
  logic spi_clk = 1'b0, spi_mosi = 1'b0, spi_cs = 1'b1;
  logic spi_miso, rx_valid, tx_ready, frame_err;
  logic [3:0] rx_index;
  logic [27:0] rx_data;
  logic tx_valid = 1'b0;
  logic [31:0] tx_data = '0;
  logic [3:0] stat_flags = '0;
  logic [12:0] stat_count = '0;
`ifdef SPI_FRAME_ERR_CNT_EN
  logic [7:0] err_cnt;
`endif
  int checks = 0, errors = 0;
  int tr_n = 0, fe_n = 0;
  logic [31:0] rx_q[$];
  logic [31:0] got;

  spi_slave_port dut (
    .clk(clk), .rst_n(rst_n), .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_cs(spi_cs),
    .spi_miso(spi_miso), .rx_valid(rx_valid), .rx_index(rx_index), .rx_data(rx_data),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .stat_flags(stat_flags), .stat_count(stat_count), .frame_err(frame_err)
`ifdef SPI_FRAME_ERR_CNT_EN
    , .err_cnt(err_cnt)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_valid) rx_q.push_back({rx_index, rx_data});
    if (tx_ready) tr_n++;
    if (frame_err) fe_n++;
  end

  task automatic xfer(input logic [31:0] mo, input int nbits, input bit end_cs, output logic [31:0] mi);
    mi = '0;
    spi_cs = 1'b0;
    #160;
    for (int i = 31; i >= 32 - nbits; i--) begin
      spi_mosi = mo[i];
      #80;
      mi = {mi[30:0], spi_miso};
      spi_clk = 1'b1;
      #80;
      spi_clk = 1'b0;
    end
    #80;
    if (end_cs) begin
      spi_cs = 1'b1;
      spi_mosi = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (4) @(negedge clk);
    checks += 6;
    if (spi_miso !== 1'b0) begin errors++; $display("FAIL reset_miso got %b want 0", spi_miso); end
    if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid got %b want 0", rx_valid); end
    if (rx_index !== 4'h0) begin errors++; $display("FAIL reset_rx_index got %h want 0", rx_index); end
    if (rx_data !== 28'h0) begin errors++; $display("FAIL reset_rx_data got %h want 0", rx_data); end
    if (tx_ready !== 1'b0) begin errors++; $display("FAIL reset_tx_ready got %b want 0", tx_ready); end
    if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err got %b want 0", frame_err); end
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_rx_status;
    int n0 = rx_q.size(), t0 = tr_n, f0 = fe_n;
    tx_valid = 1'b0;
    stat_flags = 4'b0001;
    stat_count = 13'd5;
    xfer(32'h3000_0055, 32, 1'b1, got);
    #300;
    checks += 6;
    if (rx_q.size() - n0 !== 1) begin errors++; $display("FAIL rx_count got %0d want 1", rx_q.size() - n0); end
    else begin
      if (rx_q[n0][31:28] !== 4'h3) begin errors++; $display("FAIL rx_index got %h want 3", rx_q[n0][31:28]); end
      if (rx_q[n0][27:0] !== 28'h0000055) begin errors++; $display("FAIL rx_data got %h want 0000055", rx_q[n0][27:0]); end
    end
    if (got !== 32'h0100_2800) begin errors++; $display("FAIL status_word got %h want 01002800", got); end
    if (tr_n - t0 !== 0) begin errors++; $display("FAIL status_tx_ready got %0d want 0", tr_n - t0); end
    if (fe_n - f0 !== 0) begin errors++; $display("FAIL status_frame_err got %0d want 0", fe_n - f0); end
  endtask

  task automatic test_tx_fifo;
    int n0 = rx_q.size(), t0 = tr_n;
    tx_valid = 1'b1;
    tx_data = 32'h2ABC_DEF0;
    xfer(32'h4000_0000, 32, 1'b1, got);
    #300;
    checks += 3;
    if (got !== 32'h2ABC_DEF0) begin errors++; $display("FAIL tx_word got %h want 2abcdef0", got); end
    if (tr_n - t0 !== 1) begin errors++; $display("FAIL tx_ready_pulses got %0d want 1", tr_n - t0); end
    if (rx_q.size() - n0 !== 1) begin errors++; $display("FAIL tx_rx_count got %0d want 1", rx_q.size() - n0); end
  endtask

  task automatic test_short_frame;
    int n0 = rx_q.size(), t0 = tr_n, f0 = fe_n;
    tx_valid = 1'b1;
    tx_data = 32'h2ABC_DEF0;
    xfer(32'h5555_5555, 16, 1'b1, got);
    #300;
    checks += 3;
    if (fe_n - f0 !== 1) begin errors++; $display("FAIL short_frame_err got %0d want 1", fe_n - f0); end
    if (rx_q.size() - n0 !== 0) begin errors++; $display("FAIL short_rx_valid got %0d want 0", rx_q.size() - n0); end
    if (tr_n - t0 !== 0) begin errors++; $display("FAIL short_tx_ready got %0d want 0", tr_n - t0); end
`ifdef SPI_FRAME_ERR_CNT_EN
    checks++;
    if (err_cnt !== 8'd1) begin errors++; $display("FAIL short_err_cnt got %0d want 1", err_cnt); end
`endif
    xfer(32'h6000_0006, 32, 1'b1, got);
    #300;
    checks += 2;
    if (got !== 32'h2ABC_DEF0) begin errors++; $display("FAIL resend_word got %h want 2abcdef0", got); end
    if (tr_n - t0 !== 1) begin errors++; $display("FAIL resend_tx_ready got %0d want 1", tr_n - t0); end
  endtask

  task automatic test_reset_mid_frame;
    int n0, t0, f0;
    tx_valid = 1'b0;
    xfer(32'hFFFF_FFFF, 10, 1'b0, got);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks += 6;
    if (spi_miso !== 1'b0) begin errors++; $display("FAIL midrst_miso got %b want 0", spi_miso); end
    if (rx_valid !== 1'b0) begin errors++; $display("FAIL midrst_rx_valid got %b want 0", rx_valid); end
    if (rx_index !== 4'h0) begin errors++; $display("FAIL midrst_rx_index got %h want 0", rx_index); end
    if (rx_data !== 28'h0) begin errors++; $display("FAIL midrst_rx_data got %h want 0", rx_data); end
    if (tx_ready !== 1'b0) begin errors++; $display("FAIL midrst_tx_ready got %b want 0", tx_ready); end
    if (frame_err !== 1'b0) begin errors++; $display("FAIL midrst_frame_err got %b want 0", frame_err); end
    rst_n = 1'b1;
    n0 = rx_q.size();
    t0 = tr_n;
    f0 = fe_n;
    #200;
    spi_cs = 1'b1;
    #300;
    xfer(32'h1000_0001, 32, 1'b1, got);
    #300;
    checks += 3;
    if (fe_n - f0 !== 0) begin errors++; $display("FAIL midrst_err_pulses got %0d want 0", fe_n - f0); end
    if (tr_n - t0 !== 0) begin errors++; $display("FAIL midrst_tx_pulses got %0d want 0", tr_n - t0); end
    if (rx_q.size() - n0 !== 1) begin errors++; $display("FAIL midrst_rx_count got %0d want 1", rx_q.size() - n0); end
    else begin
      checks += 2;
      if (rx_q[n0][31:28] !== 4'h1) begin errors++; $display("FAIL midrst_index got %h want 1", rx_q[n0][31:28]); end
      if (rx_q[n0][27:0] !== 28'h0000001) begin errors++; $display("FAIL midrst_data got %h want 0000001", rx_q[n0][27:0]); end
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] words [3] = '{32'hA000_0001, 32'hB123_4567, 32'hC0FF_FFFF};
    int n0 = rx_q.size(), f0 = fe_n;
    tx_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      xfer(words[k], 32, 1'b1, got);
      #100;
    end
    #300;
    checks += 2;
    if (fe_n - f0 !== 0) begin errors++; $display("FAIL b2b_frame_err got %0d want 0", fe_n - f0); end
    if (rx_q.size() - n0 !== 3) begin errors++; $display("FAIL b2b_rx_count got %0d want 3", rx_q.size() - n0); end
    else
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (rx_q[n0 + k] !== words[k]) begin errors++; $display("FAIL b2b_word%0d got %h want %h", k, rx_q[n0 + k], words[k]); end
      end
  endtask

  initial begin
    test_reset();
    test_rx_status();
    test_tx_fifo();
    test_short_frame();
    test_reset_mid_frame();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/spi_slave_port.md
SPI_SLAVE_PORT -- requirements
Module: spi_slave_port

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of synchronizer flops on spi_clk/spi_mosi/spi_cs.
REQ-002 SHALL have port clk  input  1  system clock; the clock is at least 4x the SPI clock.
REQ-003 SHALL have port rst_n  input  1  reset; synchronous, active-low.
REQ-004 SHALL have ports spi_clk, spi_mosi, spi_cs  input  1 each  SPI mode 0 from master; spi_cs is active-low.
REQ-005 SHALL have port spi_miso  output  1  serial data to master, MSB first.
REQ-006 SHALL have ports rx_valid  output  1, rx_index  output  4, rx_data  output  28: received-word strobe and payload.
REQ-007 SHALL have ports tx_valid  input  1, tx_data  input  32, tx_ready  output  1: FWFT transmit FIFO head and pop.
REQ-008 SHALL have ports stat_flags  input  4 (bits 27:24 of the status word) and stat_count  input  13 (FIFO word count).
REQ-009 SHALL have port frame_err  output  1  one-cycle pulse on a malformed frame.

Function
REQ-010 SHALL synchronize the SPI inputs through SYNC_STAGES flops and derive the spi_clk rise/fall and spi_cs fall/rise edges from the synchronized samples.
REQ-011 SHALL implement FSM IDLE -> SHIFT on spi_cs fall; SHIFT -> CHECK on spi_cs rise; CHECK -> IDLE unconditionally after one cycle.
REQ-012 SHALL, on entering SHIFT, load the tx shift register with tx_data if tx_valid, else with the status word {4'h0, stat_flags, stat_count, 11'h0}.
REQ-013 SHALL drive spi_miso from tx shift register bit 31, shifting left on each spi_clk fall; spi_miso is 0 in IDLE.
REQ-014 SHALL sample spi_mosi into the rx shift register on each spi_clk rise and count rises in a 6-bit counter saturating at 33.
REQ-015 SHALL, in CHECK with count == 32, pulse rx_valid for 1 cycle with rx_index = rx[31:28] and rx_data = rx[27:0].
REQ-016 SHALL, in CHECK with count == 32 and a FIFO word loaded in REQ-012, pulse tx_ready for 1 cycle; it never pops at load time.
REQ-017 SHALL, in CHECK with count != 32, pulse frame_err only, assert neither rx_valid nor tx_ready, and so resend the same FIFO word in the next frame.
REQ-018 SHALL ignore spi_clk edges in IDLE and CHECK.
REQ-019 SHALL hold rx_index and rx_data stable between rx_valid pulses.
REQ-020 SHALL sample tx_valid/tx_data only at the load instant; later changes during SHIFT do not affect the frame.
REQ-021 SHALL handle a spi_cs fall that coincides with CHECK by entering SHIFT on the next cycle, so back-to-back frames with a 100 ns gap are lossless.

Reset
REQ-022 SHALL, while rst_n is low, set the FSM to IDLE, zero the counter, shift registers, synchronizers, spi_miso, rx_valid, rx_index, rx_data, tx_ready and frame_err.
REQ-023 SHALL discard a frame that is interrupted by reset, with no rx_valid, tx_ready or frame_err from it.
REQ-024 SHALL, after reset is released while spi_cs is low, wait in IDLE for the next spi_cs fall.

Configuration
REQ-025 SHALL, when macro SPI_FRAME_ERR_CNT_EN is defined, add port err_cnt  output  8, an 8-bit counter that increments on each frame_err and saturates at 255, is cleared by reset, and is reported in status bits 10:3.
REQ-026 SHALL, when SPI_FRAME_ERR_CNT_EN is undefined, omit err_cnt and drive status bits 10:0 to 0.

Structure
REQ-027 SHALL take from shared package spi_slave_pkg: FRAME_BITS = 32, INDEX_W = 4, DATA_W = 28, status field positions (flags 27:24, count 23:11, errcnt 10:3), and the FSM state enum.
REQ-028 SHALL instantiate sub-module sync_edge (synchronizer plus rise/fall detect), once per SPI input.

Verification
REQ-029 SHALL cover: master sends 0x3000_0055 -> one rx_valid with rx_index 3, rx_data 0x0000055.
REQ-030 SHALL cover: tx_valid = 0, stat_flags 4'b0001, stat_count 5 -> master receives 0x0100_2800.
REQ-031 SHALL cover: tx_data 0x2ABC_DEF0 valid -> master receives 0x2ABC_DEF0 and exactly one tx_ready pulse follows the spi_cs rise.
REQ-032 SHALL cover: spi_cs raised after 16 clocks -> frame_err pulse, no rx_valid, no tx_ready; the next full frame returns 0x2ABC_DEF0 again.
REQ-033 SHALL cover: rst_n low for 2 cycles mid-frame -> all outputs 0; the next full frame 0x1000_0001 yields rx_index 1, rx_data 0x0000001.
REQ-034 SHALL cover: 3 back-to-back frames with 100 ns gaps -> 3 rx_valid pulses in order; with SPI_FRAME_ERR_CNT_EN, err_cnt stays 0.
